// File: rtl/downsampler_pkg.sv
// Shared constants and helpers for the 2x2 downsampler.
//   DATA_W_DEF : default pixel width
//   SUM_W      : 2x2 block sum width (four pixels plus rounding)
//   PAIR_W     : horizontal pair sum width stored in the line buffer
//   clog2      : ceil(log2(n)) for counter sizing
//   cnt_w      : clog2 clamped to at least one bit so degenerate sizes stay legal
package downsampler_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (clog2(n) == 0) ? 1 : clog2(n);
  endfunction

  function automatic int unsigned sum_w(input int unsigned dw);
    return dw + 2;
  endfunction

  function automatic int unsigned pair_w(input int unsigned dw);
    return dw + 1;
  endfunction

  localparam int unsigned SUM_W  = sum_w(DATA_W_DEF);
  localparam int unsigned PAIR_W = pair_w(DATA_W_DEF);

  // Row parity: even rows feed the line buffer, odd rows produce output.
  typedef enum logic {
    PH_WRITE   = 1'b0,
    PH_COMBINE = 1'b1
  } row_phase_e;

endpackage

// File: rtl/downsampler_line_buffer.sv
// Single-port synchronous RAM holding one row of horizontal pair sums.
//   clk_i   : clock
//   en_i    : port enable; read when we_i=0, write when we_i=1
//   we_i    : write enable
//   addr_i  : entry address
//   wdata_i : write data
//   rdata_o : registered read data, held until the next read
module downsampler_line_buffer
  import downsampler_pkg::*;
#(
  parameter int unsigned DEPTH = 800,
  parameter int unsigned WIDTH = PAIR_W
) (
  input  logic                    clk_i,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [cnt_w(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]        wdata_i,
  output logic [WIDTH-1:0]        rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/downsampler_2x.sv
// Streaming 2:1 decimator in both dimensions for a raster-order pixel stream.
// Emits one pixel per 2x2 input block, one cycle after the qualifying beat.
// Build option: define DOWNSAMPLER_AVG2X2_EN to output the rounded mean of
// each block (uses a line buffer); otherwise the top-left pixel is kept.
//   clock      : rising-edge clock
//   reset      : asynchronous active-low reset
//   valid/din  : input pixel strobe and data (no backpressure)
//   dataout    : downsampled pixel
//   validout   : single-cycle strobe qualifying dataout/rownum/colnum
//   rownum     : output row of dataout
//   colnum     : output column of dataout
//   frame_done : pulses with the last output pixel of a frame
module downsampler_2x
  import downsampler_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 1600,
  parameter int unsigned IN_HEIGHT = 1200,
  parameter int unsigned DATA_W    = DATA_W_DEF
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            valid,
  input  logic [DATA_W-1:0]               din,
  output logic [DATA_W-1:0]               dataout,
  output logic                            validout,
  output logic [cnt_w(IN_HEIGHT/2)-1:0]   rownum,
  output logic [cnt_w(IN_WIDTH/2)-1:0]    colnum,
  output logic                            frame_done
);

  localparam int unsigned COL_W  = cnt_w(IN_WIDTH);
  localparam int unsigned ROW_W  = cnt_w(IN_HEIGHT);
  localparam int unsigned OCOL_W = cnt_w(IN_WIDTH / 2);
  localparam int unsigned OROW_W = cnt_w(IN_HEIGHT / 2);

  logic [COL_W-1:0]  in_col_q, in_col_d;
  logic [ROW_W-1:0]  in_row_q, in_row_d;
  logic              last_col, last_row;
  row_phase_e        phase;

  logic              qualify;
  logic              fd_hit;
  logic [DATA_W-1:0] pix;

  logic [DATA_W-1:0] dataout_q, dataout_d;
  logic              validout_q, validout_d;
  logic [OROW_W-1:0] rownum_q, rownum_d;
  logic [OCOL_W-1:0] colnum_q, colnum_d;
  logic              frame_done_q, frame_done_d;

  always_comb begin
    last_col = (in_col_q == COL_W'(IN_WIDTH - 1));
    last_row = (in_row_q == ROW_W'(IN_HEIGHT - 1));
    phase    = row_phase_e'(in_row_q[0]);
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    if (valid) begin
      if (last_col) begin
        in_col_d = '0;
        in_row_d = last_row ? '0 : in_row_q + ROW_W'(1);
      end else begin
        in_col_d = in_col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_col_q <= '0;
      in_row_q <= '0;
    end else begin
      in_col_q <= in_col_d;
      in_row_q <= in_row_d;
    end
  end

`ifdef DOWNSAMPLER_AVG2X2_EN
  localparam int unsigned LB_W  = pair_w(DATA_W);
  localparam int unsigned ACC_W = sum_w(DATA_W);

  logic [DATA_W-1:0] pair_q;
  logic              lb_en, lb_we;
  logic [LB_W-1:0]   lb_wdata, lb_rdata;
  logic [ACC_W-1:0]  sum;

  // Left pixel of each horizontal pair, on both row phases.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pair_q <= '0;
    end else if (valid && !in_col_q[0]) begin
      pair_q <= din;
    end
  end

  // The buffer read is issued on the odd-row even-column beat so the
  // registered read data is ready on the odd-column beat; the read port
  // holds it across bubbles because it only updates on enabled reads.
  always_comb begin
    lb_we    = valid && (phase == PH_WRITE) && in_col_q[0];
    lb_en    = valid && ((phase == PH_WRITE) ? in_col_q[0] : !in_col_q[0]);
    lb_wdata = LB_W'(pair_q) + LB_W'(din);
    sum      = ACC_W'(lb_rdata) + ACC_W'(pair_q) + ACC_W'(din) + ACC_W'(2);
    qualify  = valid && (phase == PH_COMBINE) && in_col_q[0];
    pix      = sum[ACC_W-1:2];
    fd_hit   = last_row && last_col;
  end

  downsampler_line_buffer #(
    .DEPTH (IN_WIDTH / 2),
    .WIDTH (LB_W)
  ) u_line_buffer (
    .clk_i   (clock),
    .en_i    (lb_en),
    .we_i    (lb_we),
    .addr_i  (OCOL_W'(in_col_q >> 1)),
    .wdata_i (lb_wdata),
    .rdata_o (lb_rdata)
  );
`else
  always_comb begin
    qualify = valid && (phase == PH_WRITE) && !in_col_q[0];
    pix     = din;
    fd_hit  = (in_row_q == ROW_W'(IN_HEIGHT - 2)) && (in_col_q == COL_W'(IN_WIDTH - 2));
  end
`endif

  always_comb begin
    validout_d   = qualify;
    frame_done_d = qualify && fd_hit;
    dataout_d    = dataout_q;
    rownum_d     = rownum_q;
    colnum_d     = colnum_q;
    if (qualify) begin
      dataout_d = pix;
      rownum_d  = OROW_W'(in_row_q >> 1);
      colnum_d  = OCOL_W'(in_col_q >> 1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dataout_q    <= '0;
      validout_q   <= 1'b0;
      rownum_q     <= '0;
      colnum_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      dataout_q    <= dataout_d;
      validout_q   <= validout_d;
      rownum_q     <= rownum_d;
      colnum_q     <= colnum_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dataout    = dataout_q;
  assign validout   = validout_q;
  assign rownum     = rownum_q;
  assign colnum     = colnum_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_downsampler_2x.sv
module tb_downsampler_2x;

  localparam int unsigned W = 8;
  localparam int unsigned H = 4;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [7:0] din;
  logic [7:0] dataout;
  logic       validout;
  logic [0:0] rownum;
  logic [1:0] colnum;
  logic       frame_done;

  int checks   = 0;
  int failures = 0;
  int fd_seen  = 0;

  always #5 clock = ~clock;

  downsampler_2x #(
    .IN_WIDTH  (W),
    .IN_HEIGHT (H),
    .DATA_W    (8)
  ) dut (
    .clock      (clock),
    .reset      (rst_n),
    .valid      (valid),
    .din        (din),
    .dataout    (dataout),
    .validout   (validout),
    .rownum     (rownum),
    .colnum     (colnum),
    .frame_done (frame_done)
  );

  typedef struct {
    logic       v;
    logic [7:0] din;
    logic       exp_vo;
    logic [7:0] exp_do;
    logic [0:0] exp_row;
    logic [1:0] exp_col;
    logic       exp_fd;
  } vec_t;

  vec_t       vq[$];
  logic [7:0] pix [32];
  logic [7:0] exp_tab [8];
  logic [7:0] held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic apply(input vec_t t, input string name, input int idx);
    valid = t.v;
    din   = t.din;
    @(posedge clock);
    #1;
    if (frame_done) fd_seen++;
    chk($sformatf("%s[%0d] validout", name, idx), 32'(validout), 32'(t.exp_vo));
    chk($sformatf("%s[%0d] frame_done", name, idx), 32'(frame_done), 32'(t.exp_fd));
    chk($sformatf("%s[%0d] dataout", name, idx), 32'(dataout), 32'(t.exp_do));
    if (t.exp_vo) begin
      chk($sformatf("%s[%0d] rownum", name, idx), 32'(rownum), 32'(t.exp_row));
      chk($sformatf("%s[%0d] colnum", name, idx), 32'(colnum), 32'(t.exp_col));
    end
  endtask

  // Appends one frame of pix[] to the vector queue; bubbles=1 inserts an idle
  // cycle after every odd beat and a 10-cycle gap in the middle of row 1.
  task automatic add_frame(input bit bubbles);
    int   k;
    int   r;
    int   c;
    bit   q;
    vec_t t;
    vec_t b;
    k = 0;
    for (int i = 0; i < 32; i++) begin
      r = i / 8;
      c = i % 8;
`ifdef DOWNSAMPLER_AVG2X2_EN
      q = (r % 2 == 1) && (c % 2 == 1);
`else
      q = (r % 2 == 0) && (c % 2 == 0);
`endif
      t.v       = 1'b1;
      t.din     = pix[i];
      t.exp_vo  = q;
      t.exp_row = 1'(r / 2);
      t.exp_col = 2'(c / 2);
      t.exp_fd  = 1'b0;
      if (q) begin
        held     = exp_tab[k];
        t.exp_fd = (k == 7);
        k++;
      end
      t.exp_do = held;
      vq.push_back(t);
      if (bubbles && (i == 12 || i % 2 == 1)) begin
        b.v       = 1'b0;
        b.din     = 8'hA5;
        b.exp_vo  = 1'b0;
        b.exp_do  = held;
        b.exp_row = '0;
        b.exp_col = '0;
        b.exp_fd  = 1'b0;
        for (int g = 0; g < ((i == 12) ? 10 : 1); g++) vq.push_back(b);
      end
    end
  endtask

  task automatic run(input string name);
    for (int i = 0; i < vq.size(); i++) apply(vq[i], name, i);
    vq.delete();
    valid = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 32; i++) pix[i] = 8'(i);
`ifdef DOWNSAMPLER_AVG2X2_EN
    exp_tab = '{8'd5, 8'd7, 8'd9, 8'd11, 8'd21, 8'd23, 8'd25, 8'd27};
`else
    exp_tab = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd16, 8'd18, 8'd20, 8'd22};
`endif
  endtask

  initial begin
    int blk;
    int p;
    rst_n = 1'b0;
    valid = 1'b0;
    din   = '0;
    held  = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset validout", 32'(validout), 32'd0);
    chk("reset frame_done", 32'(frame_done), 32'd0);
    chk("reset dataout", 32'(dataout), 32'd0);
    chk("reset rownum", 32'(rownum), 32'd0);
    chk("reset colnum", 32'(colnum), 32'd0);
    rst_n = 1'b1;
    @(posedge clock);
    #1;

    load_ramp();
    add_frame(1'b0);
    run("ramp");

    add_frame(1'b1);
    run("bubble");

    for (int i = 0; i < 32; i++) pix[i] = 8'd255;
    exp_tab = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    add_frame(1'b0);
    run("sat");

    // One zero per block, at a position that rotates with the block index.
    for (int i = 0; i < 32; i++) begin
      blk    = ((i / 8) / 2) * 4 + (i % 8) / 2;
      p      = blk % 4;
      pix[i] = (((i / 8) % 2 == p / 2) && ((i % 8) % 2 == p % 2)) ? 8'd0 : 8'd1;
    end
`ifdef DOWNSAMPLER_AVG2X2_EN
    exp_tab = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
`else
    exp_tab = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd1, 8'd1};
`endif
    add_frame(1'b0);
    run("ones");

    load_ramp();
    fd_seen = 0;
    add_frame(1'b0);
    add_frame(1'b0);
    run("b2b");
    chk("b2b frame_done pulses", 32'(fd_seen), 32'd2);

    add_frame(1'b0);
    while (vq.size() > 13) void'(vq.pop_back());
    run("partial");
    #2;
    rst_n = 1'b0;
    valid = 1'b1;
    din   = 8'd99;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      chk($sformatf("midreset[%0d] validout", i), 32'(validout), 32'd0);
      chk($sformatf("midreset[%0d] dataout", i), 32'(dataout), 32'd0);
      chk($sformatf("midreset[%0d] frame_done", i), 32'(frame_done), 32'd0);
      chk($sformatf("midreset[%0d] rownum", i), 32'(rownum), 32'd0);
      chk($sformatf("midreset[%0d] colnum", i), 32'(colnum), 32'd0);
    end
    valid = 1'b0;
    rst_n = 1'b1;
    held  = '0;
    @(posedge clock);
    #1;
    add_frame(1'b0);
    run("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
